// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline register chain: size limits, slot index
// helpers and a saturating counter increment.
package pipe_pkg;

  localparam int unsigned STAGES_MAX = 8;
  localparam int unsigned CNT_W_MAX  = 32;

  function automatic int unsigned last_slot(int unsigned stages);
    return stages - 1;
  endfunction

  function automatic int unsigned slot_lsb(int unsigned idx, int unsigned width);
    return idx * width;
  endfunction

  // Counter values are carried at CNT_W_MAX bits; the caller truncates to its width.
  function automatic logic [CNT_W_MAX-1:0] sat_inc(logic [CNT_W_MAX-1:0] val,
                                                   int unsigned width);
    logic [CNT_W_MAX-1:0] max_val;
    if (width >= CNT_W_MAX) begin
      max_val = '1;
    end else begin
      max_val = (CNT_W_MAX'(1) << width) - CNT_W_MAX'(1);
    end
    return (val == max_val) ? val : val + CNT_W_MAX'(1);
  endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Handshake, hazard-control and statistics bundle of the pipeline register chain.
// The slave modport is the chain itself; the master side drives it.
interface pipe_stage_chain_if #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic                     in_valid;
  logic [DATA_W-1:0]        in_data;
  logic                     in_ready;
  logic [STAGES-1:0]        stall_req;
  logic [STAGES-1:0]        flush_req;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_ready;
  logic [STAGES-1:0]        stage_valid;
  logic [STAGES*DATA_W-1:0] stage_data;
  logic                     cnt_clr;
  logic [CNT_W-1:0]         stall_cnt;
  logic [CNT_W-1:0]         flush_cnt;

  modport master (
    output in_valid, in_data, stall_req, flush_req, out_ready, cnt_clr,
    input  in_ready, out_valid, out_data, stage_valid, stage_data, stall_cnt, flush_cnt
  );

  modport slave (
    input  in_valid, in_data, stall_req, flush_req, out_ready, cnt_clr,
    output in_ready, out_valid, out_data, stage_valid, stage_data, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_slot.sv
// One pipeline slot: valid bit plus payload. Kill beats hold beats load; the
// payload only toggles when a valid item is loaded.
module pipe_slot #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              kill_i,
  input  logic              hold_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (kill_i) begin
      valid_d = 1'b0;
    end else if (!hold_i) begin
      valid_d = load_i;
      if (load_i) begin
        data_d = load_data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised pipeline register chain with stall-driven holds, bubble collapse,
// oldest-wins redirect flush, valid/ready at both ends and saturating statistics.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int unsigned STAGES = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_stage_chain_if.slave  bus
);

  localparam int unsigned Oldest = last_slot(STAGES);

  logic [STAGES-1:0]             valid, es, ef, hold, kill, load;
  logic [STAGES-1:0][DATA_W-1:0] data, load_data;
  logic                          any_stall, any_flush, in_ready;
  logic [CNT_W-1:0]              stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  assign es        = bus.stall_req & valid;
  assign ef        = bus.flush_req & valid;
  assign any_stall = |es;
  assign any_flush = |ef;

  // A slot holds when it sits in an unbroken run of valid slots ending in a block.
  always_comb begin
    hold         = '0;
    hold[Oldest] = valid[Oldest] & (es[Oldest] | ~bus.out_ready);
    for (int i = int'(Oldest) - 1; i >= 0; i--) begin
      hold[i] = valid[i] & (es[i] | hold[i+1]);
    end
  end

  // Every slot younger than the oldest effective flush is killed.
  always_comb begin
    kill = '0;
    for (int i = int'(Oldest) - 1; i >= 0; i--) begin
      kill[i] = kill[i+1] | ef[i+1];
    end
  end

  assign in_ready = ~hold[0] & ~any_flush;

  // Killed predecessors feed a bubble, which turns an unheld flushing slot empty.
  always_comb begin
    load         = '0;
    load_data    = '0;
    load[0]      = bus.in_valid & in_ready;
    load_data[0] = bus.in_data;
    for (int i = 1; i < int'(STAGES); i++) begin
      load[i]      = valid[i-1] & ~hold[i-1] & ~kill[i-1];
      load_data[i] = data[i-1];
    end
  end

  for (genvar g = 0; g < int'(STAGES); g++) begin : g_slot
    pipe_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .kill_i      (kill[g]),
      .hold_i      (hold[g]),
      .load_i      (load[g]),
      .load_data_i (load_data[g]),
      .valid_o     (valid[g]),
      .data_o      (data[g])
    );
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (any_stall) begin
        stall_cnt_d = CNT_W'(sat_inc(CNT_W_MAX'(stall_cnt_q), CNT_W));
      end
      if (any_flush) begin
        flush_cnt_d = CNT_W'(sat_inc(CNT_W_MAX'(flush_cnt_q), CNT_W));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = valid[Oldest] & ~bus.stall_req[Oldest];
  assign bus.out_data    = data[Oldest];
  assign bus.stage_valid = valid;
  assign bus.stage_data  = data;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed and random stimulus for pipe_stage_chain, checked cycle by cycle
// against a slot-array reference model; a 2-bit-counter copy covers saturation.
module tb_pipe_stage_chain;

  localparam int unsigned STAGES = 4;
  localparam int unsigned DATA_W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pipe_stage_chain_if #(.STAGES(STAGES), .DATA_W(DATA_W), .CNT_W(16)) bus ();
  pipe_stage_chain_if #(.STAGES(STAGES), .DATA_W(DATA_W), .CNT_W(2))  sbus ();

  assign sbus.in_valid  = bus.in_valid;
  assign sbus.in_data   = bus.in_data;
  assign sbus.stall_req = bus.stall_req;
  assign sbus.flush_req = bus.flush_req;
  assign sbus.out_ready = bus.out_ready;
  assign sbus.cnt_clr   = bus.cnt_clr;

  pipe_stage_chain #(.STAGES(STAGES), .DATA_W(DATA_W), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pipe_stage_chain #(.STAGES(STAGES), .DATA_W(DATA_W), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus)
  );

  // Reference model: slot contents plus counters at both widths.
  bit                m_v [STAGES];
  logic [DATA_W-1:0] m_d [STAGES];
  int unsigned       m_sc, m_fc, m_sc2, m_fc2;
  int                n_pass   = 0;
  int                n_checks = 0;

  function automatic bit m_hold(int i);
    for (int m = i; m < int'(STAGES); m++) begin
      if (!m_v[m]) return 1'b0;
      if (bus.stall_req[m]) return 1'b1;
    end
    return !bus.out_ready;
  endfunction

  function automatic bit m_any_flush();
    for (int i = 0; i < int'(STAGES); i++) begin
      if (m_v[i] && bus.flush_req[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(STAGES); i++) begin
      m_v[i] = 1'b0;
      m_d[i] = '0;
    end
    m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(string tag);
    logic [STAGES-1:0] ev;
    for (int i = 0; i < int'(STAGES); i++) ev[i] = m_v[i];
    chk({tag, " stage_valid"}, 64'(bus.stage_valid), 64'(ev));
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'(!m_hold(0) && !m_any_flush()));
    chk({tag, " out_valid"}, 64'(bus.out_valid),
        64'(m_v[STAGES-1] && !bus.stall_req[STAGES-1]));
    if (m_v[STAGES-1]) chk({tag, " out_data"}, 64'(bus.out_data), 64'(m_d[STAGES-1]));
    for (int i = 0; i < int'(STAGES); i++) begin
      if (m_v[i]) begin
        chk($sformatf("%s slot%0d data", tag, i),
            64'(bus.stage_data[i*DATA_W +: DATA_W]), 64'(m_d[i]));
      end
    end
    chk({tag, " stall_cnt"}, 64'(bus.stall_cnt), 64'(m_sc));
    chk({tag, " flush_cnt"}, 64'(bus.flush_cnt), 64'(m_fc));
    chk({tag, " stall_cnt_sat"}, 64'(sbus.stall_cnt), 64'(m_sc2));
    chk({tag, " flush_cnt_sat"}, 64'(sbus.flush_cnt), 64'(m_fc2));
  endtask

  // Compute next slot state from the current inputs, then commit at the edge.
  task automatic model_step();
    bit                nv [STAGES];
    logic [DATA_W-1:0] nd [STAGES];
    int                k;
    bit                rdy, st, fl;
    k   = -1;
    st  = 1'b0;
    fl  = 1'b0;
    rdy = !m_hold(0) && !m_any_flush();
    for (int i = 0; i < int'(STAGES); i++) begin
      if (m_v[i] && bus.flush_req[i]) begin k = i; fl = 1'b1; end
      if (m_v[i] && bus.stall_req[i]) st = 1'b1;
    end
    for (int i = 0; i < int'(STAGES); i++) begin
      nv[i] = m_v[i];
      nd[i] = m_d[i];
      if (i < k) begin
        nv[i] = 1'b0;
      end else if (m_hold(i)) begin
        nv[i] = m_v[i];
      end else if (i == k) begin
        nv[i] = 1'b0;
      end else if (i == 0) begin
        nv[i] = bus.in_valid && rdy;
        if (nv[i]) nd[i] = bus.in_data;
      end else begin
        nv[i] = m_v[i-1] && !m_hold(i-1);
        nd[i] = m_d[i-1];
      end
    end
    @(posedge clk);
    for (int i = 0; i < int'(STAGES); i++) begin
      m_v[i] = nv[i];
      m_d[i] = nd[i];
    end
    if (bus.cnt_clr) begin
      m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
    end else begin
      if (st) begin
        if (m_sc < 65535) m_sc++;
        if (m_sc2 < 3) m_sc2++;
      end
      if (fl) begin
        if (m_fc < 65535) m_fc++;
        if (m_fc2 < 3) m_fc2++;
      end
    end
  endtask

  task automatic drive(logic v, logic [DATA_W-1:0] d, logic [STAGES-1:0] st,
                       logic [STAGES-1:0] fl, logic ordy, logic clr, string tag);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.stall_req = st;
    bus.flush_req = fl;
    bus.out_ready = ordy;
    bus.cnt_clr   = clr;
    #1;
    check_all(tag);
    model_step();
    @(negedge clk);
  endtask

  task automatic drain(string tag);
    for (int i = 0; i < int'(STAGES); i++) drive(1'b0, '0, '0, '0, 1'b1, 1'b0, tag);
  endtask

  initial begin
    logic [STAGES-1:0] st, fl;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.stall_req = '0;
    bus.flush_req = '0;
    bus.out_ready = 1'b1;
    bus.cnt_clr   = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #2 check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Free flow
    for (int i = 0; i < 8; i++) drive(1'b1, 32'h10 + i, '0, '0, 1'b1, 1'b0, "flow");
    drain("flow_drain");

    // Load-use stall on slot 1
    drive(1'b1, 32'hA1, '0, '0, 1'b1, 1'b0, "stall_fill");
    drive(1'b1, 32'hA0, '0, '0, 1'b1, 1'b0, "stall_fill");
    drive(1'b1, 32'hA2, 4'b0010, '0, 1'b1, 1'b0, "stall");
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, "stall_after");
    drain("stall_drain");

    // Branch flush from slot 2
    for (int i = 0; i < 3; i++) drive(1'b1, 32'hB0 + i, '0, '0, 1'b1, 1'b0, "flush_fill");
    drive(1'b1, 32'hBB, '0, 4'b0100, 1'b1, 1'b0, "flush");
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, "flush_after");
    drain("flush_drain");

    // Backpressure with a bubble at slot 2
    drive(1'b1, 32'hC0, '0, '0, 1'b1, 1'b0, "bp_fill");
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, "bp_fill");
    drive(1'b1, 32'hC1, '0, '0, 1'b1, 1'b0, "bp_fill");
    drive(1'b1, 32'hC2, '0, '0, 1'b1, 1'b0, "bp_fill");
    for (int i = 0; i < 3; i++) drive(1'b1, 32'hC3 + i, '0, '0, 1'b0, 1'b0, "bp");
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, "bp_release");
    drain("bp_drain");

    // Simultaneous flushes on a full pipe
    for (int i = 0; i < 4; i++) drive(1'b1, 32'hD0 + i, '0, '0, 1'b1, 1'b0, "mflush_fill");
    drive(1'b1, 32'hD4, '0, 4'b1010, 1'b1, 1'b0, "mflush");
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, "mflush_after");
    drain("mflush_drain");

    // Long stall saturates the narrow counter, then async reset mid-stream
    for (int i = 0; i < 4; i++) drive(1'b1, 32'hE0 + i, '0, '0, 1'b1, 1'b0, "sat_fill");
    for (int i = 0; i < 5; i++) drive(1'b1, 32'hE8, 4'b1000, '0, 1'b1, 1'b0, "sat_stall");
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, "sat_check");
    rst_n = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Clear has priority over a concurrent stall increment
    drive(1'b1, 32'hF0, '0, '0, 1'b1, 1'b0, "clr_fill");
    drive(1'b0, '0, 4'b0001, '0, 1'b1, 1'b0, "clr_stall");
    drive(1'b0, '0, 4'b0001, '0, 1'b1, 1'b1, "clr");
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, "clr_after");
    drain("clr_drain");

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      st = ($urandom_range(0, 4) == 0) ? STAGES'($urandom) : '0;
      fl = ($urandom_range(0, 7) == 0) ? STAGES'($urandom) : '0;
      drive(1'($urandom_range(0, 3) != 0), DATA_W'($urandom), st, fl,
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised replacement for the hand-instantiated pr_if_id / pr_id_ex / pr_ex_mem / pr_mem_wb register chain.
- Holds STAGES pipeline slots, each with a payload and a valid bit. Handles hazard stalls with bubble insertion, redirect flushes that kill younger stages, and valid/ready backpressure at both ends.
- Sits between instruction fetch (input) and write-back/retire (output), and carries stall/flush statistics counters.

Parameters:
- STAGES, 4, number of pipeline slots (2..8); slot 0 is youngest, slot STAGES-1 is oldest.
- DATA_W, 32, payload width per slot.
- CNT_W, 16, width of the saturating stall and flush counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream has a payload.
- in_data  input  DATA_W  upstream payload.
- in_ready  output  1  slot 0 accepts this cycle.
- stall_req  input  STAGES  bit i: slot i must hold (hazard).
- flush_req  input  STAGES  bit i: slot i redirects; kill all slots younger than i.
- out_valid  output  1  oldest slot presents a payload.
- out_data  output  DATA_W  payload of slot STAGES-1.
- out_ready  input  1  downstream accepts.
- stage_valid  output  STAGES  per-slot valid.
- stage_data  output  STAGES*DATA_W  flattened per-slot payload; slot i is at bits [i*DATA_W +: DATA_W].
- cnt_clr  input  1  synchronous clear of both counters.
- stall_cnt  output  CNT_W  cycles with any effective stall.
- flush_cnt  output  CNT_W  cycles with any effective flush.

Behaviour:
- Reset (async, rst_n=0): all valid bits 0, all payloads 0, counters 0. Outputs settle immediately: out_valid=0, stage_valid=0. in_ready follows from the combinational rules below.
- Effective requests are masked by valid:
  - es[i] = stall_req[i] & valid[i]
  - ef[i] = flush_req[i] & valid[i]
  - Requests on empty slots are ignored.
- Hold chain (combinational):
  - hold[S-1] = valid[S-1] & (es[S-1] | ~out_ready)
  - hold[i] = valid[i] & (es[i] | hold[i+1])
  - Empty slots never hold, so bubbles collapse.
- out_valid = valid[S-1] & ~stall_req[S-1]. A transfer occurs when out_valid & out_ready.
- in_ready = ~hold[0] & ~(|ef). An input is accepted when in_valid & in_ready.
- Next state when no flush is active:
  - A held slot keeps its contents.
  - Otherwise slot i loads from slot i-1 with valid = valid[i-1] & ~hold[i-1]. A held predecessor therefore yields a bubble (valid 0, payload don't-care).
  - Slot 0 loads in_data with valid = in_valid & in_ready.
- Flush: let k = highest index with ef[k]=1.
  - Slots j<k get valid 0 next cycle, regardless of hold.
  - Slot k keeps its contents if hold[k]; otherwise it becomes a bubble.
  - Slots above k follow the normal rules.
  - Multiple flushes: the oldest wins, which is a superset kill.
- Flush and stall on the same slot: the slot holds and younger slots are killed.
- Latency: a payload accepted at edge n appears at out_data after edge n+STAGES-1 if nothing holds. Throughput is 1 per cycle.
- Counters:
  - Each counter increments by 1 per cycle with |es (stall) or |ef (flush).
  - They saturate at 2^CNT_W-1.
  - cnt_clr has priority over increment.
- Payload registers update only on load, to save power. Bubble payloads are not required to be zero.

Decomposition:
- Shared package pipe_pkg:
  - limits STAGES_MAX=8;
  - a saturating-increment function;
  - localparam slot index helpers.
- One sub-module, pipe_slot: a single valid+payload register with load/hold/kill inputs and async reset.
- The chain logic (hold, flush priority, counters) stays in pipe_stage_chain.

Test Plan:
1. Free flow: STAGES=4, out_ready=1, push 0x10..0x17 back-to-back → in_ready stays 1; out_data sequence is 0x10..0x17 starting 3 edges after the first accept; counters stay 0.
2. Load-use stall: slot1=0xA1, slot0=0xA0, stall_req[1]=1 for one cycle → slots 0/1 unchanged, slot2 valid=0 next cycle, in_ready=0 that cycle, stall_cnt=1.
3. Branch flush: slots 0–2 valid, flush_req[2]=1 → slots 0/1 valid=0 next cycle, input 0xBB not accepted, slot2 advances to slot3, flush_cnt=1.
4. Backpressure with bubble collapse: slots 0,1,3 valid, slot2 empty, out_ready=0 for 3 cycles → slot3 holds; slots 0/1 advance to fill slot2 then hold; in_ready drops only once slots 0–3 are full.
5. Simultaneous flushes: flush_req=4'b1010 with the pipe full → slots 0–2 invalid next cycle, slot3 payload retires normally.
6. Reset mid-stream, plus saturation with CNT_W=2:
   - Hold stall 5 cycles → stall_cnt=3.
   - Assert rst_n=0 between edges → stage_valid=0, out_valid=0, counters 0 immediately.
   - cnt_clr with stall present → counter reads 0.
